// File: rtl/es_imm_decode_stage_if.sv
// Valid/ready bundle between fetch and the immediate-generation stage.
// The master drives instructions in and accepts results.
// The slave is the stage itself.
interface es_imm_decode_stage_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [2:0]       out_fmt;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_instr, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_tag
    );

    modport slave (
        input  in_valid, in_instr, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_tag
    );
endinterface

// File: rtl/es_imm_decode_stage.sv
// Registered RV32I/RV64I immediate generator with a 2-entry skid buffer.
// Each instruction is classified into an immediate format and its
// XLEN-wide immediate is built. Accepted illegal opcodes are counted.
// in_ready comes straight from the skid-full flop, so it never
// combinationally depends on out_ready.
module es_imm_decode_stage #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    es_imm_decode_stage_if.slave bus,
    output logic [CNT_W-1:0]     illegal_cnt
);
    localparam logic [2:0] FMT_I    = 3'd0;
    localparam logic [2:0] FMT_S    = 3'd1;
    localparam logic [2:0] FMT_B    = 3'd2;
    localparam logic [2:0] FMT_U    = 3'd3;
    localparam logic [2:0] FMT_J    = 3'd4;
    localparam logic [2:0] FMT_Z    = 3'd5;
    localparam logic [2:0] FMT_NONE = 3'd6;
    localparam logic [2:0] FMT_ILL  = 3'd7;

    // Map the opcode to an immediate format. The 32-bit-word opcodes
    // (OP-IMM-32 and OP-32) exist only on RV64.
    function automatic logic [2:0] classify(input logic [31:0] ins);
        logic [2:0] f;
        f = FMT_ILL;
        if (ins[1:0] == 2'b11) begin
            case (ins[6:0])
                7'b0000011, 7'b0010011,
                7'b1100111, 7'b0001111: f = FMT_I;
                7'b1110011:             f = ins[14] ? FMT_Z : FMT_I;
                7'b0100011:             f = FMT_S;
                7'b1100011:             f = FMT_B;
                7'b0110111, 7'b0010111: f = FMT_U;
                7'b1101111:             f = FMT_J;
                7'b0110011:             f = FMT_NONE;
                7'b0011011:             f = (XLEN == 64) ? FMT_I : FMT_ILL;
                7'b0111011:             f = (XLEN == 64) ? FMT_NONE : FMT_ILL;
                default:                f = FMT_ILL;
            endcase
        end
        return f;
    endfunction

    // Build the 32-bit signed immediate first, then sign-extend it to XLEN.
    // The CSR zimm has bit 31 clear, so this extension leaves it zero-extended.
    function automatic logic [XLEN-1:0] build_imm(input logic [31:0] ins,
                                                  input logic [2:0]  f);
        logic signed [31:0] v;
        case (f)
            FMT_I:   v = {{20{ins[31]}}, ins[31:20]};
            FMT_S:   v = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            FMT_B:   v = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
            FMT_U:   v = {ins[31:12], 12'b0};
            FMT_J:   v = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
            FMT_Z:   v = {27'b0, ins[19:15]};
            default: v = '0;
        endcase
        return XLEN'(v);
    endfunction

    // The counter holds at its maximum value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    logic             out_valid_q, out_valid_d;
    logic [XLEN-1:0]  out_imm_q,   out_imm_d;
    logic [2:0]       out_fmt_q,   out_fmt_d;
    logic [TAG_W-1:0] out_tag_q,   out_tag_d;
    logic             skid_full_q, skid_full_d;
    logic [XLEN-1:0]  skid_imm_q,  skid_imm_d;
    logic [2:0]       skid_fmt_q,  skid_fmt_d;
    logic [TAG_W-1:0] skid_tag_q,  skid_tag_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;

    logic [2:0]       in_fmt;
    logic [XLEN-1:0]  in_imm;
    logic             accept;
    logic             out_free;

    // Decode the offered instruction and qualify the two handshakes.
    always_comb begin
        in_fmt   = classify(bus.in_instr);
        in_imm   = build_imm(bus.in_instr, in_fmt);
        accept   = bus.in_valid & ~skid_full_q & ~flush;
        out_free = ~out_valid_q | bus.out_ready;
    end

    // Next state: the skid entry always drains ahead of newer input.
    always_comb begin
        out_valid_d = out_valid_q;
        out_imm_d   = out_imm_q;
        out_fmt_d   = out_fmt_q;
        out_tag_d   = out_tag_q;
        skid_full_d = skid_full_q;
        skid_imm_d  = skid_imm_q;
        skid_fmt_d  = skid_fmt_q;
        skid_tag_d  = skid_tag_q;
        cnt_d       = cnt_q;
        if (accept && in_fmt == FMT_ILL) begin
            cnt_d = sat_inc(cnt_q);
        end
        if (flush) begin
            out_valid_d = 1'b0;
            skid_full_d = 1'b0;
        end else if (out_free) begin
            if (skid_full_q) begin
                out_valid_d = 1'b1;
                out_imm_d   = skid_imm_q;
                out_fmt_d   = skid_fmt_q;
                out_tag_d   = skid_tag_q;
                skid_full_d = accept;
                if (accept) begin
                    skid_imm_d = in_imm;
                    skid_fmt_d = in_fmt;
                    skid_tag_d = bus.in_tag;
                end
            end else begin
                out_valid_d = accept;
                if (accept) begin
                    out_imm_d = in_imm;
                    out_fmt_d = in_fmt;
                    out_tag_d = bus.in_tag;
                end
            end
        end else if (accept) begin
            skid_full_d = 1'b1;
            skid_imm_d  = in_imm;
            skid_fmt_d  = in_fmt;
            skid_tag_d  = bus.in_tag;
        end
    end

    // State registers. Reset clears every entry so that nothing survives it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_imm_q   <= '0;
            out_fmt_q   <= FMT_NONE;
            out_tag_q   <= '0;
            skid_full_q <= 1'b0;
            skid_imm_q  <= '0;
            skid_fmt_q  <= FMT_NONE;
            skid_tag_q  <= '0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_imm_q   <= out_imm_d;
            out_fmt_q   <= out_fmt_d;
            out_tag_q   <= out_tag_d;
            skid_full_q <= skid_full_d;
            skid_imm_q  <= skid_imm_d;
            skid_fmt_q  <= skid_fmt_d;
            skid_tag_q  <= skid_tag_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.in_ready  = ~skid_full_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_imm   = out_imm_q;
    assign bus.out_fmt   = out_fmt_q;
    assign bus.out_tag   = out_tag_q;
    assign illegal_cnt   = cnt_q;
endmodule

// File: tb/tb_es_imm_decode_stage.sv
// Bench for es_imm_decode_stage. Three instances are driven by identical
// stimulus: RV32 with a 16-bit counter, RV32 with a 2-bit counter, and
// RV64. The transaction-level model holds a queue of accepted
// instructions, and a compare process checks all three instances on
// every falling edge.
module tb_es_imm_decode_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_instr = '0;
    logic [31:0] in_tag = '0;

    always #5 clk = ~clk;

    es_imm_decode_stage_if #(.XLEN(32), .TAG_W(32)) b32 ();
    es_imm_decode_stage_if #(.XLEN(32), .TAG_W(32)) b32c ();
    es_imm_decode_stage_if #(.XLEN(64), .TAG_W(32)) b64 ();

    assign b32.in_valid   = in_valid;
    assign b32.in_instr   = in_instr;
    assign b32.in_tag     = in_tag;
    assign b32.out_ready  = out_ready;
    assign b32c.in_valid  = in_valid;
    assign b32c.in_instr  = in_instr;
    assign b32c.in_tag    = in_tag;
    assign b32c.out_ready = out_ready;
    assign b64.in_valid   = in_valid;
    assign b64.in_instr   = in_instr;
    assign b64.in_tag     = in_tag;
    assign b64.out_ready  = out_ready;

    logic [15:0] cnt32;
    logic [1:0]  cnt32c;
    logic [15:0] cnt64;

    es_imm_decode_stage #(.XLEN(32), .TAG_W(32), .CNT_W(16)) u32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(b32), .illegal_cnt(cnt32));
    es_imm_decode_stage #(.XLEN(32), .TAG_W(32), .CNT_W(2)) u32c (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(b32c), .illegal_cnt(cnt32c));
    es_imm_decode_stage #(.XLEN(64), .TAG_W(32), .CNT_W(16)) u64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(b64), .illegal_cnt(cnt64));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- model ----------------
    typedef struct {
        logic [31:0] ins;
        logic [31:0] tag;
    } ent_t;
    ent_t q[$];
    int   m_cnt32 = 0;
    int   m_cnt32c = 0;
    int   m_cnt64 = 0;

    function automatic int m_fmt(input logic [31:0] ins, input int xlen);
        if (ins[1:0] != 2'b11) return 7;
        case (ins[6:0])
            7'h03, 7'h13, 7'h67, 7'h0F: return 0;
            7'h73: return ins[14] ? 5 : 0;
            7'h23: return 1;
            7'h63: return 2;
            7'h37, 7'h17: return 3;
            7'h6F: return 4;
            7'h33: return 6;
            7'h1B: return (xlen == 64) ? 0 : 7;
            7'h3B: return (xlen == 64) ? 6 : 7;
            default: return 7;
        endcase
    endfunction

    function automatic logic [63:0] m_imm(input logic [31:0] ins, input int xlen);
        longint v;
        case (m_fmt(ins, xlen))
            0: v = longint'($signed(ins[31:20]));
            1: v = longint'($signed({ins[31:25], ins[11:7]}));
            2: v = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            3: v = longint'($signed({ins[31:12], 12'b0}));
            4: v = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
            5: v = longint'(ins[19:15]);
            default: v = 0;
        endcase
        if (xlen == 32) return {32'b0, v[31:0]};
        return v;
    endfunction

    function automatic int m_sat(input int c, input int maxv);
        return (c >= maxv) ? maxv : c + 1;
    endfunction

    // Model update at each clock edge, or cleared on reset.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                q.delete();
                m_cnt32 = 0;
                m_cnt32c = 0;
                m_cnt64 = 0;
            end else begin
                bit   acc;
                ent_t e;
                acc = in_valid && (q.size() < 2) && !flush;
                if (flush) begin
                    q.delete();
                end else begin
                    if (q.size() > 0 && out_ready) void'(q.pop_front());
                    if (acc) begin
                        e.ins = in_instr;
                        e.tag = in_tag;
                        q.push_back(e);
                    end
                end
                if (acc && m_fmt(in_instr, 32) == 7) begin
                    m_cnt32 = m_sat(m_cnt32, 65535);
                    m_cnt32c = m_sat(m_cnt32c, 3);
                end
                if (acc && m_fmt(in_instr, 64) == 7) m_cnt64 = m_sat(m_cnt64, 65535);
            end
        end
    end

    task automatic check_inst(input string p, input int xlen, input logic vld,
                              input logic rdy, input logic [63:0] imm,
                              input logic [2:0] fmt, input logic [31:0] tag,
                              input logic [63:0] cnt, input int mcnt);
        chk({p, "_out_valid"}, {63'b0, vld}, {63'b0, q.size() > 0});
        chk({p, "_in_ready"}, {63'b0, rdy}, {63'b0, q.size() < 2});
        chk({p, "_illegal_cnt"}, cnt, 64'(mcnt));
        if (q.size() > 0) begin
            chk({p, "_out_tag"}, {32'b0, tag}, {32'b0, q[0].tag});
            chk({p, "_out_fmt"}, {61'b0, fmt}, 64'(m_fmt(q[0].ins, xlen)));
            chk({p, "_out_imm"}, imm, m_imm(q[0].ins, xlen));
        end
    endtask

    // Compare process: every falling edge outside reset.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check_inst("x32", 32, b32.out_valid, b32.in_ready, {32'b0, b32.out_imm},
                           b32.out_fmt, b32.out_tag, {48'b0, cnt32}, m_cnt32);
                check_inst("x32c", 32, b32c.out_valid, b32c.in_ready, {32'b0, b32c.out_imm},
                           b32c.out_fmt, b32c.out_tag, {62'b0, cnt32c}, m_cnt32c);
                check_inst("x64", 64, b64.out_valid, b64.in_ready, b64.out_imm,
                           b64.out_fmt, b64.out_tag, {48'b0, cnt64}, m_cnt64);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] tg,
                       input logic rdy, input logic fl);
        in_valid  = v;
        in_instr  = ins;
        in_tag    = tg;
        out_ready = rdy;
        flush     = fl;
        @(negedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string p);
        chk({p, "_rst_valid"}, {63'b0, b32.out_valid}, 64'd0);
        chk({p, "_rst_ready"}, {63'b0, b32.in_ready}, 64'd1);
        chk({p, "_rst_imm"}, {32'b0, b32.out_imm}, 64'd0);
        chk({p, "_rst_fmt"}, {61'b0, b32.out_fmt}, 64'd6);
        chk({p, "_rst_tag"}, {32'b0, b32.out_tag}, 64'd0);
        chk({p, "_rst_cnt"}, {48'b0, cnt32}, 64'd0);
        chk({p, "_rst_imm64"}, b64.out_imm, 64'd0);
    endtask

    initial begin
        logic [15:0] cnt_before;

        // Pin the model against hand-computed values.
        chk("pin_addi32", m_imm(32'hFFF00093, 32), 64'hFFFF_FFFF);
        chk("pin_sw", m_imm(32'hFE112E23, 32), 64'hFFFF_FFFC);
        chk("pin_lui", m_imm(32'h123452B7, 32), 64'h1234_5000);
        chk("pin_csrrwi", m_imm(32'h300FD073, 32), 64'h1F);
        chk("pin_addiw64", m_imm(32'h8000029B, 64), 64'hFFFF_FFFF_FFFF_F800);
        chk("pin_addiw32_fmt", 64'(m_fmt(32'h8000029B, 32)), 64'd7);
        chk("pin_lui64", m_imm(32'h800002B7, 64), 64'hFFFF_FFFF_8000_0000);

        repeat (2) @(negedge clk);
        #1;
        chk_reset_state("init");
        rst_n = 1'b1;

        // Formats, out_ready held high.
        cyc(1, 32'hFFF00093, 32'd10, 1, 0);
        chk("addi_fmt", {61'b0, b32.out_fmt}, 64'd0);
        chk("addi_imm", {32'b0, b32.out_imm}, 64'hFFFF_FFFF);
        chk("addi_imm64", b64.out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        cyc(1, 32'hFE112E23, 32'd11, 1, 0);
        chk("sw_fmt", {61'b0, b32.out_fmt}, 64'd1);
        chk("sw_imm", {32'b0, b32.out_imm}, 64'hFFFF_FFFC);
        cyc(1, 32'h123452B7, 32'd12, 1, 0);
        chk("lui_imm", {32'b0, b32.out_imm}, 64'h1234_5000);
        cyc(1, 32'h300FD073, 32'd13, 1, 0);
        chk("csr_fmt", {61'b0, b32.out_fmt}, 64'd5);
        chk("csr_imm", {32'b0, b32.out_imm}, 64'h1F);
        cyc(1, 32'h00000033, 32'd14, 1, 0);
        chk("add_fmt", {61'b0, b32.out_fmt}, 64'd6);
        cyc(1, 32'h8000029B, 32'd15, 1, 0);
        chk("addiw32_fmt", {61'b0, b32.out_fmt}, 64'd7);
        chk("addiw64_fmt", {61'b0, b64.out_fmt}, 64'd0);
        chk("addiw64_imm", b64.out_imm, 64'hFFFF_FFFF_FFFF_F800);
        cyc(1, 32'h800002B7, 32'd16, 1, 0);
        chk("lui64_imm", b64.out_imm, 64'hFFFF_FFFF_8000_0000);
        chk("lui32_imm", {32'b0, b32.out_imm}, 64'h8000_0000);
        cyc(1, 32'h00000000, 32'd17, 1, 0);
        cyc(1, 32'h0000007F, 32'd18, 1, 0);
        chk("ill_fmt", {61'b0, b32.out_fmt}, 64'd7);
        chk("ill_imm", {32'b0, b32.out_imm}, 64'd0);
        chk("ill_cnt64", {48'b0, cnt64}, 64'd2);
        chk("ill_cnt32", {48'b0, cnt32}, 64'd3);
        cyc(0, 32'h0, 32'd0, 1, 0);
        chk("drain_valid", {63'b0, b32.out_valid}, 64'd0);

        // Backpressure: tags 1 and 2 are held, and tag 3 waits.
        cyc(1, 32'hFFF00093, 32'd1, 0, 0);
        cyc(1, 32'hFE112E23, 32'd2, 0, 0);
        chk("bp_ready_low", {63'b0, b32.in_ready}, 64'd0);
        cyc(1, 32'h123452B7, 32'd3, 0, 0);
        chk("bp_hold_tag", {32'b0, b32.out_tag}, 64'd1);
        chk("bp_hold_imm", {32'b0, b32.out_imm}, 64'hFFFF_FFFF);
        cyc(1, 32'h123452B7, 32'd3, 1, 0);
        chk("bp_tag2", {32'b0, b32.out_tag}, 64'd2);
        cyc(1, 32'h123452B7, 32'd3, 1, 0);
        chk("bp_tag3", {32'b0, b32.out_tag}, 64'd3);
        cyc(0, 32'h0, 32'd0, 1, 0);
        chk("bp_drained", {63'b0, b32.out_valid}, 64'd0);

        // Asynchronous reset with both entries occupied.
        cyc(1, 32'h00000000, 32'd4, 0, 0);
        cyc(1, 32'h00000013, 32'd5, 0, 0);
        rst_n = 1'b0;
        #1;
        chk_reset_state("mid");
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        // Counter saturation on the 2-bit instance.
        for (int i = 0; i < 5; i++) cyc(1, 32'h00000000, 32'(40 + i), 1, 0);
        chk("sat_cnt2", {62'b0, cnt32c}, 64'd3);
        chk("sat_cnt16", {48'b0, cnt32}, 64'd5);

        // Flush while the skid entry is full and an input is offered.
        cyc(1, 32'hFFF00093, 32'd20, 0, 0);
        cyc(1, 32'h00000000, 32'd21, 0, 0);
        chk("fl_pre_ready", {63'b0, b32.in_ready}, 64'd0);
        cnt_before = cnt32;
        cyc(1, 32'h0000007F, 32'd22, 0, 1);
        chk("fl_valid", {63'b0, b32.out_valid}, 64'd0);
        chk("fl_ready", {63'b0, b32.in_ready}, 64'd1);
        chk("fl_cnt", {48'b0, cnt32}, {48'b0, cnt_before});
        cyc(0, 32'h0, 32'd0, 1, 0);
        chk("fl_not_presented", {63'b0, b32.out_valid}, 64'd0);

        // Traffic after the flush, with out_ready toggling.
        for (int i = 0; i < 8; i++) cyc(1, 32'h004000EF + 32'(i << 21), 32'(60 + i), 1'(i % 2), 0);
        repeat (3) cyc(0, 32'h0, 32'd0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
